// File: rtl/p_to_s_sched.sv
// p_to_s_sched: round-robin scheduler that lets NREQ requesters share one
// parallel-to-serial converter. A granted word is placed on ser_data and the
// serializer is enabled (ser_en low) for one leading-zero cycle plus WIDTH
// data cycles. A mandatory one-cycle gap with ser_en high follows, so the
// serializer's internal counter clears before the next word.
//
// Ports:
//   clk       rising-edge clock
//   rst       asynchronous active-high reset
//   req       per-requester request, held until its gnt pulse
//   req_data  requester i word at [i*WIDTH +: WIDTH]
//   abort     cancels the transfer in progress (ignored outside SHIFT)
//   gnt       one-hot, one-cycle pulse when a word is captured
//   ser_en    active-low serializer enable (0 = shifting)
//   ser_data  captured word, held until the next grant
//   owner     index of the requester owning the current or last transfer
//   busy      high while a transfer is in progress (inverse of ser_en)
//   done      one-cycle pulse on normal completion
//
// state  | meaning
// IDLE   | no transfer; arbitrate every cycle
// SHIFT  | serializer enabled; counter runs 0..WIDTH
// GAP    | one cycle with ser_en high; arbitrate as in IDLE
module p_to_s_sched #(
    parameter int WIDTH = 16,
    parameter int NREQ  = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NREQ-1:0]            req,
    input  logic [NREQ*WIDTH-1:0]      req_data,
    input  logic                       abort,
    output logic [NREQ-1:0]            gnt,
    output logic                       ser_en,
    output logic [WIDTH-1:0]           ser_data,
    output logic [$clog2(NREQ)-1:0]    owner,
    output logic                       busy,
    output logic                       done
);
    localparam int PW = $clog2(NREQ);
    localparam int CW = $clog2(WIDTH + 2);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic            win_any;
    logic [PW-1:0]   win_idx;
    logic [PW:0]     scan;

    logic [NREQ-1:0]  gnt_d;
    logic             ser_en_d;
    logic [WIDTH-1:0] ser_data_d;
    logic [PW-1:0]    owner_d;
    logic             done_d;

    // Round-robin search starting at ptr_q; one extra bit on scan keeps the
    // wrap correct for NREQ values that are not a power of two.
    always_comb begin
        win_any = 1'b0;
        win_idx = '0;
        scan    = '0;
        for (int k = 0; k < NREQ; k++) begin
            scan = {1'b0, ptr_q} + (PW+1)'(k);
            if (scan >= (PW+1)'(NREQ))
                scan = scan - (PW+1)'(NREQ);
            if (!win_any && req[scan[PW-1:0]]) begin
                win_any = 1'b1;
                win_idx = scan[PW-1:0];
            end
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_GAP: state_d = win_any ? S_SHIFT : S_IDLE;
            S_SHIFT: begin
                if (abort || cnt_q == CW'(WIDTH))
                    state_d = S_GAP;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic: next values for the registered outputs, counter, pointer
    always_comb begin
        gnt_d      = '0;
        ser_en_d   = 1'b1;
        ser_data_d = ser_data;
        owner_d    = owner;
        done_d     = 1'b0;
        cnt_d      = cnt_q;
        ptr_d      = ptr_q;
        case (state_q)
            S_IDLE, S_GAP: begin
                if (win_any) begin
                    gnt_d[win_idx] = 1'b1;
                    ser_en_d       = 1'b0;
                    ser_data_d     = req_data[int'(win_idx)*WIDTH +: WIDTH];
                    owner_d        = win_idx;
                    cnt_d          = '0;
                    ptr_d          = (win_idx == PW'(NREQ-1)) ? '0 : win_idx + 1'b1;
                end
            end
            S_SHIFT: begin
                if (abort) begin
                    cnt_d = '0;
                end else if (cnt_q == CW'(WIDTH)) begin
                    done_d = 1'b1;
                    cnt_d  = '0;
                end else begin
                    ser_en_d = 1'b0;
                    cnt_d    = cnt_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt      <= '0;
            ser_en   <= 1'b1;
            ser_data <= '0;
            owner    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            cnt_q    <= '0;
            ptr_q    <= '0;
        end else begin
            gnt      <= gnt_d;
            ser_en   <= ser_en_d;
            ser_data <= ser_data_d;
            owner    <= owner_d;
            busy     <= ~ser_en_d;
            done     <= done_d;
            cnt_q    <= cnt_d;
            ptr_q    <= ptr_d;
        end
    end
endmodule
